// File: rtl/seg_display_pkg.sv
// Shared types, segment table and BCD digit arithmetic for seg_display_ctrl.
package seg_display_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'b00,
        MODE_MANUAL   = 2'b01,
        MODE_RUN_UP   = 2'b10,
        MODE_RUN_DOWN = 2'b11
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g..a}; codes 10-15 cannot occur in the count and show blank.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

    // Returns {carry_out, digit}.
    function automatic logic [4:0] bcd_inc_digit(input logic [3:0] digit, input logic carry_in);
        if (!carry_in)
            return {1'b0, digit};
        if (digit >= 4'd9)
            return {1'b1, 4'd0};
        return {1'b0, digit + 4'd1};
    endfunction

    // Returns {borrow_out, digit}.
    function automatic logic [4:0] bcd_dec_digit(input logic [3:0] digit, input logic borrow_in);
        if (!borrow_in)
            return {1'b0, digit};
        if (digit == 4'd0)
            return {1'b1, 4'd9};
        return {1'b0, digit - 4'd1};
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and press-pulse generator for one active-low key.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic btn_n,
    output logic pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          db_level;
    logic          armed;
    logic [CW-1:0] stable_cnt;
    logic          ref_level;

    // Until a clean release has been seen after reset, the key is treated as
    // held, so a key pressed through reset never yields a press pulse.
    assign ref_level = armed ? db_level : 1'b0;

    always_ff @(posedge clk_clk) begin
        sync_q <= {sync_q[0], btn_n};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            db_level   <= 1'b1;
            armed      <= 1'b0;
            stable_cnt <= '0;
            pressed    <= 1'b0;
        end else begin
            pressed <= 1'b0;
            if (sync_q[1] == ref_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_cnt <= '0;
                db_level   <= sync_q[1];
                armed      <= 1'b1;
                pressed    <= armed & ~sync_q[1];
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// BCD up/down counter with button-driven mode FSM and registered 7-segment output.
// Define SEG_DISPLAY_BLINK_EN to blink the display while in HOLD.
//
// state         | meaning
// MODE_HOLD     | count frozen, step ignored
// MODE_MANUAL   | each step press adds 1
// MODE_RUN_UP   | count +1 every TICK_CYCLES
// MODE_RUN_DOWN | count -1 every TICK_CYCLES
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_CYCLES     = 50000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [2:0]              buttons,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [4*NUM_DIGITS-1:0] count_value,
    output logic [1:0]              mode,
    output logic                    overflow
);

    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_CYCLES < 1) begin : g_bad_param
        $error("seg_display_ctrl: illegal parameter value");
    end

    logic          step_ev, mode_ev, clear_ev;
    mode_t         mode_q;
    logic [DW-1:0] count_q, inc_val, dec_val, load_val;
    logic          carry, borrow, inc_wrap, dec_wrap;
    logic [TW-1:0] tick_cnt;
    logic          run_mode, tick_done, step_up, step_dn;
    logic [HW-1:0] seg_val, hex_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .btn_n(buttons[0]), .pressed(step_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .btn_n(buttons[1]), .pressed(mode_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .btn_n(buttons[2]), .pressed(clear_ev)
    );

    always_comb begin
        carry    = 1'b1;
        borrow   = 1'b1;
        inc_val  = '0;
        dec_val  = '0;
        load_val = '0;
        seg_val  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            {carry, inc_val[4*i +: 4]}  = bcd_inc_digit(count_q[4*i +: 4], carry);
            {borrow, dec_val[4*i +: 4]} = bcd_dec_digit(count_q[4*i +: 4], borrow);
            load_val[4*i +: 4]          = bcd_clamp(wr_data[4*i +: 4]);
            seg_val[7*i +: 7]           = SEG_TABLE[count_q[4*i +: 4]];
        end
        inc_wrap = carry;
        dec_wrap = borrow;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mode_q <= MODE_HOLD;
        end else if (mode_ev) begin
            unique case (mode_q)
                MODE_HOLD:     mode_q <= MODE_MANUAL;
                MODE_MANUAL:   mode_q <= MODE_RUN_UP;
                MODE_RUN_UP:   mode_q <= MODE_RUN_DOWN;
                MODE_RUN_DOWN: mode_q <= MODE_HOLD;
            endcase
        end
    end

    assign run_mode  = (mode_q == MODE_RUN_UP) || (mode_q == MODE_RUN_DOWN);
    assign tick_done = run_mode && (tick_cnt == TW'(TICK_CYCLES - 1));
    // Steps are judged against the current mode, so a mode press in the same
    // cycle does not suppress them.
    assign step_up   = ((mode_q == MODE_MANUAL) && step_ev) || ((mode_q == MODE_RUN_UP) && tick_done);
    assign step_dn   = (mode_q == MODE_RUN_DOWN) && tick_done;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            count_q  <= '0;
            overflow <= 1'b0;
            tick_cnt <= '0;
        end else begin
            overflow <= 1'b0;
            if (clear_ev) begin
                count_q <= '0;
            end else if (wr_en) begin
                count_q <= load_val;
            end else if (step_up) begin
                count_q  <= inc_val;
                overflow <= inc_wrap;
            end else if (step_dn) begin
                count_q  <= dec_val;
                overflow <= dec_wrap;
            end

            if (!run_mode || mode_ev || clear_ev || wr_en || tick_done)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);
        end
    end

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clk_clk) begin
        if (reset_reset || mode_q != MODE_HOLD) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign hex_next = blink_off ? {NUM_DIGITS{SEG_BLANK}} : seg_val;
`else
    assign hex_next = seg_val;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            hex_out <= {NUM_DIGITS{SEG_TABLE[0]}};
        else
            hex_out <= hex_next;
    end

    assign count_value = count_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomised self-checking bench for seg_display_ctrl against a decimal-integer model.
module tb_seg_display_ctrl;

    localparam int ND    = 6;
    localparam int DEB   = 4;
    localparam int TICK  = 8;
    localparam int BLINK = 16;
    localparam int MOD   = 1000000;
    // Edge (counted from the first edge that sees a key low) on which a press
    // acts: two synchroniser stages, DEB stable samples, then the press pulse.
    localparam int EVENT_EDGE = DEB + 3;
    localparam int HOLD_LEN   = DEB + 6;
    localparam logic [6:0] SEG_REF [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic [2:0]        buttons = 3'b111;
    logic              wr_en = 1'b0;
    logic [4*ND-1:0]   wr_data = '0;
    logic [7*ND-1:0]   hex_out;
    logic [4*ND-1:0]   count_value;
    logic [1:0]        mode;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_seen = 0;
    int m_count  = 0;

    seg_display_ctrl #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .buttons(buttons),
        .wr_en(wr_en), .wr_data(wr_data), .hex_out(hex_out),
        .count_value(count_value), .mode(mode), .overflow(overflow)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) begin
        #1;
        if (overflow) ovf_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*ND-1:0] raw);
        int r = 0;
        int p = 1;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(raw[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [7*ND-1:0] seg_of(input int v);
        logic [7*ND-1:0] h;
        for (int i = 0; i < ND; i++) begin
            h[7*i +: 7] = SEG_REF[v % 10];
            v = v / 10;
        end
        return h;
    endfunction

    task automatic press(input int idx);
        buttons[idx] = 1'b0;
        cycles(HOLD_LEN);
        buttons[idx] = 1'b1;
        cycles(HOLD_LEN);
    endtask

    // Leaves the bench one negedge after the loading edge.
    task automatic load(input logic [4*ND-1:0] raw);
        wr_en   = 1'b1;
        wr_data = raw;
        cycles(1);
        wr_en   = 1'b0;
        m_count = clamp_val(raw);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count_value, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_hex"}, hex_out, seg_of(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, v, m, steps, ovf0, exp_ovf, diff;
        logic [4*ND-1:0] raw;

        cycles(3);
        chk_reset_state("reset");
        reset_reset = 1'b0;
        cycles(20);

        // Short glitch is rejected, a long press gives exactly one step.
        buttons[1] = 1'b0; cycles(3); buttons[1] = 1'b1; cycles(15);
        chk("glitch_mode", mode, 0);
        buttons[1] = 1'b0; cycles(10); buttons[1] = 1'b1; cycles(15);
        chk("mode_once", mode, 1);

        load(24'h999999);
        cycles(2);
        chk("load_999999", count_value, 24'h999999);
        ovf0 = ovf_seen;
        press(0);
        chk("wrap_up_count", count_value, 0);
        chk("wrap_up_ovf", ovf_seen - ovf0, 1);
        m_count = 0;

        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 3);
            ovf0 = ovf_seen;
            exp_ovf = 0;
            if (op <= 1) begin
                press(0);
                if (m_count == MOD - 1) exp_ovf = 1;
                m_count = (m_count + 1) % MOD;
            end else if (op == 2) begin
                raw = ($urandom_range(0, 3) == 0) ? 24'h999999 : 24'($urandom);
                load(raw);
                cycles(2);
            end else begin
                press(2);
                m_count = 0;
            end
            chk($sformatf("man%0d_count", it), count_value, to_bcd(m_count));
            chk($sformatf("man%0d_hex", it), hex_out, seg_of(m_count));
            chk($sformatf("man%0d_ovf", it), ovf_seen - ovf0, exp_ovf);
        end

        // Clear and load land on the same edge.
        load(24'h777777);
        buttons[2] = 1'b0;
        cycles(EVENT_EDGE - 1);
        chk("prio_pre", count_value, 24'h777777);
        wr_en = 1'b1; wr_data = 24'h123456;
        cycles(1);
        wr_en = 1'b0;
        cycles(HOLD_LEN - EVENT_EDGE);
        buttons[2] = 1'b1;
        cycles(HOLD_LEN);
        chk("prio_clear", count_value, 0);

        load(24'h00A0F1);
        cycles(2);
        chk("clamp_load", count_value, 24'h009091);
        chk("clamp_hex", hex_out, seg_of(9091));

        // Mode and step together: step counts under MANUAL, then one RUN_UP tick.
        buttons[1:0] = 2'b00;
        cycles(HOLD_LEN);
        buttons[1:0] = 2'b11;
        cycles(HOLD_LEN);
        chk("mode_step_mode", mode, 2);
        chk("mode_step_count", count_value, to_bcd(9093));

        for (int it = 0; it < 6; it++) begin
            v = ($urandom_range(0, 2) == 0) ? MOD - 1 - $urandom_range(0, 3) : $urandom_range(0, MOD - 1);
            load(to_bcd(v));
            ovf0 = ovf_seen;
            m = $urandom_range(5, 40);
            cycles(m);
            steps = m / TICK;
            chk($sformatf("up%0d_count", it), count_value, to_bcd((v + steps) % MOD));
            chk($sformatf("up%0d_ovf", it), ovf_seen - ovf0, (v + steps) / MOD);
        end

        press(1);
        chk("run_down_mode", mode, 3);
        load(0);
        ovf0 = ovf_seen;
        cycles(7);
        chk("down_pre_tick", count_value, 0);
        cycles(1);
        chk("down_wrap_count", count_value, 24'h999999);
        chk("down_wrap_ovf", overflow, 1);
        cycles(1);
        chk("down_ovf_drop", overflow, 0);
        cycles(7);
        chk("down_second", count_value, 24'h999998);
        chk("down_ovf_total", ovf_seen - ovf0, 1);

        for (int it = 0; it < 6; it++) begin
            v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, MOD - 1);
            load(to_bcd(v));
            ovf0 = ovf_seen;
            m = $urandom_range(5, 40);
            cycles(m);
            steps = m / TICK;
            chk($sformatf("dn%0d_count", it), count_value, to_bcd((v - steps + MOD) % MOD));
            chk($sformatf("dn%0d_ovf", it), ovf_seen - ovf0, (v < steps) ? 1 : 0);
        end

        press(1);
        chk("hold_mode", mode, 0);
        v = $urandom_range(0, MOD - 1);
        load(to_bcd(v));
        cycles(2);
        press(0);
        chk("hold_step_ignored", count_value, to_bcd(v));

`ifdef SEG_DISPLAY_BLINK_EN
        begin
            int run, runs_ok, runs_bad, bad_val;
            logic started;
            logic [7*ND-1:0] prev;
            run = 0; runs_ok = 0; runs_bad = 0; bad_val = 0; started = 1'b0;
            prev = hex_out;
            for (int c = 0; c < 90; c++) begin
                cycles(1);
                if (hex_out !== seg_of(v) && hex_out !== '1) bad_val++;
                if (hex_out !== prev) begin
                    if (started) begin
                        if (run == BLINK) runs_ok++;
                        else runs_bad++;
                    end
                    started = 1'b1;
                    run = 1;
                end else begin
                    run++;
                end
                prev = hex_out;
            end
            chk("blink_values", bad_val, 0);
            chk("blink_bad_runs", runs_bad, 0);
            chk("blink_enough_runs", runs_ok >= 3, 1);
        end
`else
        diff = 0;
        for (int c = 0; c < 90; c++) begin
            cycles(1);
            if (hex_out !== seg_of(v)) diff++;
        end
        chk("hold_hex_const", diff, 0);
`endif

        // Reset while step is held: no step until released and pressed again.
        buttons[0] = 1'b0;
        cycles(10);
        reset_reset = 1'b1;
        cycles(1);
        chk_reset_state("mid_reset");
        reset_reset = 1'b0;
        cycles(20);
        press(1);
        chk("post_reset_mode", mode, 1);
        cycles(20);
        chk("held_no_step", count_value, 0);
        buttons[0] = 1'b1;
        cycles(15);
        press(0);
        chk("repress_step", count_value, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
